// File: rtl/uart_led_cmd_parser_if.sv
// Byte-stream and LED-command signals between the UART receiver side and the packet parser.
// UART_LED_CMD_ACK_EN adds the acknowledge handshake toward the UART transmitter.
interface uart_led_cmd_parser_if;
  logic        i_Received;
  logic [7:0]  i_Data;
  logic        o_Write;
  logic [7:0]  o_Led_Addr;
  logic [23:0] o_Led_RGB;
  logic        o_Error;
  logic [7:0]  o_Err_Count;
  logic        o_Busy;
`ifdef UART_LED_CMD_ACK_EN
  logic        o_Ack_Start;
  logic [7:0]  o_Ack_Data;
  logic        i_Tx_Busy;

  modport master (
    output i_Received, i_Data, i_Tx_Busy,
    input  o_Write, o_Led_Addr, o_Led_RGB, o_Error, o_Err_Count, o_Busy,
           o_Ack_Start, o_Ack_Data
  );
  modport slave (
    input  i_Received, i_Data, i_Tx_Busy,
    output o_Write, o_Led_Addr, o_Led_RGB, o_Error, o_Err_Count, o_Busy,
           o_Ack_Start, o_Ack_Data
  );
`else
  modport master (
    output i_Received, i_Data,
    input  o_Write, o_Led_Addr, o_Led_RGB, o_Error, o_Err_Count, o_Busy
  );
  modport slave (
    input  i_Received, i_Data,
    output o_Write, o_Led_Addr, o_Led_RGB, o_Error, o_Err_Count, o_Busy
  );
`endif
endinterface

// File: rtl/uart_led_cmd_parser.sv
// Frames 6-byte LED packets (SYNC,ADDR,R,G,B,CHK) from the UART rx flag and emits LED writes.
// Optional ack-byte handshake enabled by defining UART_LED_CMD_ACK_EN.
module uart_led_cmd_parser #(
  parameter int          NUM_LEDS       = 16,
  parameter logic [7:0]  SYNC_BYTE      = 8'hAA,
  parameter int          TIMEOUT_CYCLES = 80000
) (
  input logic               i_Clock,
  input logic               i_Reset_n,
  uart_led_cmd_parser_if.slave bus
);

  localparam logic [2:0] HUNT  = 3'd0;
  localparam logic [2:0] ADDR  = 3'd1;
  localparam logic [2:0] RED   = 3'd2;
  localparam logic [2:0] GREEN = 3'd3;
  localparam logic [2:0] BLUE  = 3'd4;
  localparam logic [2:0] CHECK = 3'd5;

  localparam int              CntW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] TimeoutMax = CntW'(TIMEOUT_CYCLES);
  localparam logic [8:0]      NumLedsW   = 9'(NUM_LEDS);

  logic            rx_q;
  logic [2:0]      state_q, state_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      red_q, red_d;
  logic [7:0]      green_q, green_d;
  logic [7:0]      blue_q, blue_d;
  logic [7:0]      chkAcc_q, chkAcc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            write_q, write_d;
  logic            error_q, error_d;
  logic [7:0]      ledAddr_q, ledAddr_d;
  logic [23:0]     ledRgb_q, ledRgb_d;
  logic [7:0]      errCount_q, errCount_d;
  logic            byteStrobe;

  // rx_q resets high so a flag already up at reset release is not mistaken for a new byte
  assign byteStrobe = bus.i_Received & ~rx_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    red_d      = red_q;
    green_d    = green_q;
    blue_d     = blue_q;
    chkAcc_d   = chkAcc_q;
    ledAddr_d  = ledAddr_q;
    ledRgb_d   = ledRgb_q;
    errCount_d = errCount_q;
    write_d    = 1'b0;
    error_d    = 1'b0;

    // A byte arriving in the same cycle as the timeout takes priority over it
    if (byteStrobe || state_q == HUNT) begin
      cnt_d = '0;
    end else if (cnt_q == TimeoutMax) begin
      cnt_d   = '0;
      state_d = HUNT;
      error_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end

    if (byteStrobe) begin
      case (state_q)
        HUNT: if (bus.i_Data == SYNC_BYTE) state_d = ADDR;
        ADDR: begin
          addr_d   = bus.i_Data;
          chkAcc_d = bus.i_Data;
          state_d  = RED;
        end
        RED: begin
          red_d    = bus.i_Data;
          chkAcc_d = chkAcc_q ^ bus.i_Data;
          state_d  = GREEN;
        end
        GREEN: begin
          green_d  = bus.i_Data;
          chkAcc_d = chkAcc_q ^ bus.i_Data;
          state_d  = BLUE;
        end
        BLUE: begin
          blue_d   = bus.i_Data;
          chkAcc_d = chkAcc_q ^ bus.i_Data;
          state_d  = CHECK;
        end
        CHECK: begin
          state_d = HUNT;
          if (bus.i_Data == chkAcc_q && {1'b0, addr_q} < NumLedsW) begin
            ledAddr_d = addr_q;
            ledRgb_d  = {red_q, green_q, blue_q};
            write_d   = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    if (error_d && errCount_q != 8'hFF) errCount_d = errCount_q + 8'd1;
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      rx_q       <= 1'b1;
      state_q    <= HUNT;
      addr_q     <= '0;
      red_q      <= '0;
      green_q    <= '0;
      blue_q     <= '0;
      chkAcc_q   <= '0;
      cnt_q      <= '0;
      write_q    <= 1'b0;
      error_q    <= 1'b0;
      ledAddr_q  <= '0;
      ledRgb_q   <= '0;
      errCount_q <= '0;
    end else begin
      rx_q       <= bus.i_Received;
      state_q    <= state_d;
      addr_q     <= addr_d;
      red_q      <= red_d;
      green_q    <= green_d;
      blue_q     <= blue_d;
      chkAcc_q   <= chkAcc_d;
      cnt_q      <= cnt_d;
      write_q    <= write_d;
      error_q    <= error_d;
      ledAddr_q  <= ledAddr_d;
      ledRgb_q   <= ledRgb_d;
      errCount_q <= errCount_d;
    end
  end

  assign bus.o_Write     = write_q;
  assign bus.o_Error     = error_q;
  assign bus.o_Led_Addr  = ledAddr_q;
  assign bus.o_Led_RGB   = ledRgb_q;
  assign bus.o_Err_Count = errCount_q;
  assign bus.o_Busy      = (state_q != HUNT);

`ifdef UART_LED_CMD_ACK_EN
  logic       ackStart_q, ackStart_d;
  logic [7:0] ackData_q, ackData_d;

  // A fresh packet outcome overrides both a pending ack and the tx-busy release
  always_comb begin
    ackStart_d = ackStart_q;
    ackData_d  = ackData_q;
    if (ackStart_q && bus.i_Tx_Busy) ackStart_d = 1'b0;
    if (byteStrobe && state_q == CHECK) begin
      ackStart_d = 1'b1;
      ackData_d  = write_d ? 8'h06 : 8'h15;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      ackStart_q <= 1'b0;
      ackData_q  <= '0;
    end else begin
      ackStart_q <= ackStart_d;
      ackData_q  <= ackData_d;
    end
  end

  assign bus.o_Ack_Start = ackStart_q;
  assign bus.o_Ack_Data  = ackData_q;
`endif

endmodule
